if_fetch_unit: RTL and testbench

- Instruction-fetch stage with a merged IF/ID pipeline register; feeds the decode stage with pc_o / inst_o.
- Sequences the PC and fetches instructions over a req/ack instruction-memory handshake.
- Parks a returned instruction while the pipeline is stalled.
- Applies branch/jump redirects resolved in decode, honouring the single MIPS delay slot.

---
 rtl/if_fetch_unit_pkg.sv | 15 +
 rtl/if_hold_buf.sv | 40 ++++
 rtl/if_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, constants and FSM encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        FETCH_ST = 1'b0,
        HOLD_ST  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid register that parks a fetched PC/instruction pair while decode is stalled.
module if_hold_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_inst,
    output logic [ADDR_W-1:0] buf_pc,
    output logic [DATA_W-1:0] buf_inst,
    output logic              buf_valid
);

    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] inst_reg;
    logic              valid_reg;

    // A load takes priority so a drain and refill in the same cycle keeps the new entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= '0;
            inst_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            pc_reg    <= load_pc;
            inst_reg  <= load_inst;
            valid_reg <= 1'b1;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign buf_pc    = pc_reg;
    assign buf_inst  = inst_reg;
    assign buf_valid = valid_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch with merged IF/ID register, stall parking and delay-slot-aware redirects.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_ack_i,
    input  logic [INST_W-1:0] inst_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o
);

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] id_pc_reg, id_pc_next;
    logic [INST_W-1:0] id_inst_reg, id_inst_next;
    logic              id_valid_reg, id_valid_next;
    logic              pend_reg, pend_next;
    logic [ADDR_W-1:0] pend_target_reg, pend_target_next;

    logic              hb_load, hb_drain, hb_valid;
    logic [ADDR_W-1:0] hb_pc;
    logic [INST_W-1:0] hb_inst;

    logic              live_br;
    logic              advance;
    logic [ADDR_W-1:0] redirect_pc;

    if_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (INST_W)
    ) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (hb_load),
        .drain     (hb_drain),
        .load_pc   (pc_reg),
        .load_inst (inst_data_i),
        .buf_pc    (hb_pc),
        .buf_inst  (hb_inst),
        .buf_valid (hb_valid)
    );

    // Decode only flags the branch sitting in IF/ID, so a bubble there can never redirect.
    assign live_br = id_valid_reg & branch_flag_i;

    always_comb begin
        if (live_br)
            redirect_pc = branch_target_address_i;
        else if (pend_reg)
            redirect_pc = pend_target_reg;
        else
            redirect_pc = pc_reg + ADDR_W'(PC_STEP);
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        id_pc_next       = id_pc_reg;
        id_inst_next     = id_inst_reg;
        id_valid_next    = id_valid_reg;
        pend_next        = pend_reg;
        pend_target_next = pend_target_reg;
        hb_load          = 1'b0;
        hb_drain         = 1'b0;
        inst_req_o       = 1'b0;
        advance          = 1'b0;

        case (state_reg)
            FETCH_ST: begin
                inst_req_o = !rst;
                if (inst_ack_i) begin
                    if (!stall_i) begin
                        advance       = 1'b1;
                        id_pc_next    = pc_reg;
                        id_inst_next  = inst_data_i;
                        id_valid_next = 1'b1;
                    end else begin
                        hb_load    = 1'b1;
                        state_next = HOLD_ST;
                    end
                end else if (!stall_i) begin
                    id_pc_next    = '0;
                    id_inst_next  = ZERO_WORD;
                    id_valid_next = 1'b0;
                    // The branch leaves IF/ID before its delay slot arrives; remember where to go.
                    if (live_br) begin
                        pend_next        = 1'b1;
                        pend_target_next = branch_target_address_i;
                    end
                end
            end
            HOLD_ST: begin
                if (!stall_i) begin
                    advance       = 1'b1;
                    hb_drain      = 1'b1;
                    id_pc_next    = hb_pc;
                    id_inst_next  = hb_inst;
                    id_valid_next = hb_valid;
                    state_next    = FETCH_ST;
                end
            end
            default: state_next = FETCH_ST;
        endcase

        if (advance) begin
            pc_next = redirect_pc;
            if (live_br || pend_reg)
                pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FETCH_ST;
            pc_reg          <= RESET_PC;
            id_pc_reg       <= '0;
            id_inst_reg     <= ZERO_WORD;
            id_valid_reg    <= 1'b0;
            pend_reg        <= 1'b0;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            id_pc_reg       <= id_pc_next;
            id_inst_reg     <= id_inst_next;
            id_valid_reg    <= id_valid_next;
            pend_reg        <= pend_next;
            pend_target_reg <= pend_target_next;
        end
    end

    assign inst_addr_o  = {pc_reg[ADDR_W-1:2], 2'b00};
    assign pc_o         = id_pc_reg;
    assign inst_o       = id_inst_reg;
    assign inst_valid_o = id_valid_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Cycle-vector bench for if_fetch_unit with a scoreboard of delivered PC/instruction pairs.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i = 1'b0;
    logic [31:0] inst_data_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_i                 (stall_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_req_o              (inst_req_o),
        .inst_addr_o             (inst_addr_o),
        .inst_ack_i              (inst_ack_i),
        .inst_data_i             (inst_data_i),
        .pc_o                    (pc_o),
        .inst_o                  (inst_o),
        .inst_valid_o            (inst_valid_o)
    );

    // Inputs for one cycle plus the outputs expected during that cycle.
    typedef struct {
        logic        rst;
        logic        stall;
        logic        ack;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = '0;

    task automatic add(input logic r, input logic s, input logic a, input logic b,
                       input logic [31:0] t, input logic q, input logic [31:0] ad,
                       input logic [31:0] p, input logic v);
        vec_t e;
        e.rst = r; e.stall = s; e.ack = a; e.br = b; e.tgt = t;
        e.req = q; e.addr = ad; e.pc = p; e.valid = v;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    initial begin
        //   rst stall ack br  tgt            req addr           pc             valid
        add(1, 0, 0, 0, 32'h0,         0, 32'h000, 32'h000, 0);  // reset state
        add(0, 0, 1, 0, 32'h0,         1, 32'h000, 32'h000, 0);  // back-to-back acks
        add(0, 0, 1, 0, 32'h0,         1, 32'h004, 32'h000, 1);
        add(0, 0, 1, 0, 32'h0,         1, 32'h008, 32'h004, 1);
        add(0, 0, 1, 0, 32'h0,         1, 32'h00C, 32'h008, 1);
        add(0, 0, 0, 0, 32'h0,         1, 32'h010, 32'h00C, 1);  // ack delayed 3 cycles
        add(0, 0, 0, 0, 32'h0,         1, 32'h010, 32'h000, 0);
        add(0, 0, 0, 0, 32'h0,         1, 32'h010, 32'h000, 0);
        add(0, 0, 1, 0, 32'h0,         1, 32'h010, 32'h000, 0);
        add(0, 1, 1, 0, 32'h0,         1, 32'h014, 32'h010, 1);  // ack under stall -> HOLD
        add(0, 1, 0, 0, 32'h0,         0, 32'h014, 32'h010, 1);
        add(0, 1, 0, 0, 32'h0,         0, 32'h014, 32'h010, 1);
        add(0, 1, 0, 0, 32'h0,         0, 32'h014, 32'h010, 1);
        add(0, 0, 1, 0, 32'h0,         0, 32'h014, 32'h010, 1);  // release; stray ack ignored
        add(0, 0, 1, 0, 32'h0,         1, 32'h018, 32'h014, 1);
        add(0, 0, 1, 0, 32'h0,         1, 32'h01C, 32'h018, 1);
        add(0, 0, 1, 0, 32'h0,         1, 32'h020, 32'h01C, 1);
        add(0, 0, 1, 1, 32'h100,       1, 32'h024, 32'h020, 1);  // live branch at 0x20
        add(0, 0, 1, 0, 32'h0,         1, 32'h100, 32'h024, 1);
        add(0, 0, 1, 0, 32'h0,         1, 32'h104, 32'h100, 1);
        add(0, 0, 1, 0, 32'h0,         1, 32'h108, 32'h104, 1);
        add(0, 0, 0, 1, 32'h200,       1, 32'h10C, 32'h108, 1);  // branch leaves before slot
        add(0, 0, 0, 0, 32'h0,         1, 32'h10C, 32'h000, 0);
        add(0, 0, 1, 0, 32'h0,         1, 32'h10C, 32'h000, 0);  // slot uses pending target
        add(0, 0, 1, 0, 32'h0,         1, 32'h200, 32'h10C, 1);
        add(0, 0, 0, 0, 32'h0,         1, 32'h204, 32'h200, 1);
        add(1, 0, 1, 0, 32'h0,         0, 32'h204, 32'h000, 0);  // reset with ack outstanding
        add(0, 0, 0, 0, 32'h0,         1, 32'h000, 32'h000, 0);
        add(0, 0, 1, 0, 32'h0,         1, 32'h000, 32'h000, 0);
        add(0, 0, 0, 0, 32'h0,         1, 32'h004, 32'h000, 1);
        add(0, 0, 0, 0, 32'h0,         1, 32'h004, 32'h000, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] exp_inst;
            v = vecs[i];
            @(negedge clk);
            rst                     = v.rst;
            stall_i                 = v.stall;
            inst_ack_i              = v.ack;
            branch_flag_i           = v.br;
            branch_target_address_i = v.tgt;
            inst_data_i             = v.req ? (v.addr ^ KEY) : JUNK;
            #1;
            n_vec++;
            exp_inst = v.valid ? (v.pc ^ KEY) : 32'h0;
            $display("vec %0d: rst=%0b stall=%0b ack=%0b br=%0b | req=%0b addr=%h pc=%h inst=%h valid=%0b",
                     i, v.rst, v.stall, v.ack, v.br, inst_req_o, inst_addr_o, pc_o, inst_o, inst_valid_o);
            check($sformatf("req[%0d]", i),   {31'b0, inst_req_o},   {31'b0, v.req});
            check($sformatf("addr[%0d]", i),  inst_addr_o,           v.addr);
            check($sformatf("pc[%0d]", i),    pc_o,                  v.pc);
            check($sformatf("inst[%0d]", i),  inst_o,                exp_inst);
            check($sformatf("valid[%0d]", i), {31'b0, inst_valid_o}, {31'b0, v.valid});

            // A newly delivered instruction retires the oldest accepted fetch.
            if (inst_valid_o === 1'b1 && (!prev_valid || pc_o !== prev_pc)) begin
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty[%0d]: got pc %h, expected no delivery", i, pc_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("sb_pc[%0d]", i),   pc_o,   e.pc);
                    check($sformatf("sb_inst[%0d]", i), inst_o, e.inst);
                end
            end
            prev_valid = inst_valid_o;
            prev_pc    = pc_o;

            if (v.ack && v.req) begin
                exp_t e;
                e.pc   = v.addr;
                e.inst = v.addr ^ KEY;
                sb_q.push_back(e);
            end
        end

        @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
